// File: rtl/cmd_pkg.sv
// Shared types and constants for the command sequencer and the vector datapath.
package cmd_pkg;

  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_MUL = 4'h3,
    OP_DOT = 4'h4
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OP      = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5
  } state_e;

  // An opcode byte is legal only with a clear upper nibble and a known operation.
  function automatic logic is_valid_op(input logic [7:0] b);
    logic known;
    case (b[3:0])
      OP_ADD, OP_SUB, OP_MUL, OP_DOT: known = 1'b1;
      default:                        known = 1'b0;
    endcase
    return known && (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte timeout counter for cmd_sequencer; exists only when CMD_SEQ_TIMEOUT_EN is defined.
`ifdef CMD_SEQ_TIMEOUT_EN
module cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside timed states, restarted by every consumed byte.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || kick) begin
      cnt_d = '0;
    end else if (expired) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/cmd_sequencer.sv
// Parses opcode/length/A/B packets from the input FIFO, fills the operand RAM and launches the
// vector unit. Defining CMD_SEQ_TIMEOUT_EN adds an inter-byte timeout in LEN/LOAD_A/LOAD_B.
module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ADDR_W  = $clog2(MAX_LEN)
`ifdef CMD_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 32'd1_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              in_read,
  output logic              vec_we,
  output logic              vec_sel,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [7:0]        vec_wdata,
  output logic              exec_start,
  output logic [3:0]        exec_op,
  output logic [ADDR_W:0]   exec_len,
  input  logic              exec_done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int LEN_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              vec_we_q, vec_we_d;
  logic              vec_sel_q, vec_sel_d;
  logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
  logic [7:0]        vec_wdata_q, vec_wdata_d;
  logic              exec_start_q, exec_start_d;
  logic [3:0]        exec_op_q, exec_op_d;
  logic [LEN_W-1:0]  exec_len_q, exec_len_d;
  logic              busy_q;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic pop_s;
  logic timed_s;
  logic last_s;
  logic tmo_s;

  // in_read is combinational so a first-word-fall-through byte can be taken every cycle.
  assign pop_s   = in_ready && !rst &&
                   (state_q inside {S_IDLE, S_LEN, S_LOAD_A, S_LOAD_B});
  assign timed_s = state_q inside {S_LEN, S_LOAD_A, S_LOAD_B};
  assign last_s  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

`ifdef CMD_SEQ_TIMEOUT_EN
  cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (timed_s),
    .kick   (pop_s),
    .expired(tmo_s)
  );
`else
  assign tmo_s = 1'b0;
`endif

  // Next-state and next-output logic for the packet parser.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    len_d        = len_q;
    idx_d        = idx_q;
    vec_we_d     = 1'b0;
    vec_sel_d    = vec_sel_q;
    vec_addr_d   = vec_addr_q;
    vec_wdata_d  = vec_wdata_q;
    exec_start_d = 1'b0;
    exec_op_d    = exec_op_q;
    exec_len_d   = exec_len_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          op_d = in_data[3:0];
          if (is_valid_op(in_data)) begin
            state_d = S_LEN;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_OP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LEN: begin
        if (pop_s) begin
          if ((in_data == 8'd0) || (in_data > 8'(MAX_LEN))) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_IDLE;
          end else begin
            len_d   = in_data[LEN_W-1:0];
            idx_d   = '0;
            state_d = S_LOAD_A;
          end
        end else if (tmo_s) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_IDLE;
        end else begin
          state_d = S_LEN;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (pop_s) begin
          vec_we_d    = 1'b1;
          vec_sel_d   = (state_q == S_LOAD_B);
          vec_addr_d  = idx_q;
          vec_wdata_d = in_data;
          if (last_s) begin
            idx_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else if (tmo_s) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          idx_d      = '0;
          state_d    = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end

      S_START: begin
        exec_start_d = 1'b1;
        exec_op_d    = op_q;
        exec_len_d   = len_q;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        if (exec_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 4'h0;
      len_q        <= '0;
      idx_q        <= '0;
      vec_we_q     <= 1'b0;
      vec_sel_q    <= 1'b0;
      vec_addr_q   <= '0;
      vec_wdata_q  <= 8'h00;
      exec_start_q <= 1'b0;
      exec_op_q    <= 4'h0;
      exec_len_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      vec_we_q     <= vec_we_d;
      vec_sel_q    <= vec_sel_d;
      vec_addr_q   <= vec_addr_d;
      vec_wdata_q  <= vec_wdata_d;
      exec_start_q <= exec_start_d;
      exec_op_q    <= exec_op_d;
      exec_len_q   <= exec_len_d;
      busy_q       <= (state_d != S_IDLE);
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign in_read    = pop_s;
  assign vec_we     = vec_we_q;
  assign vec_sel    = vec_sel_q;
  assign vec_addr   = vec_addr_q;
  assign vec_wdata  = vec_wdata_q;
  assign exec_start = exec_start_q;
  assign exec_op    = exec_op_q;
  assign exec_len   = exec_len_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed self-checking bench for cmd_sequencer: FWFT byte FIFO model, write/err/start monitor.
module tb_cmd_sequencer;
  import cmd_pkg::*;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_ready = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_read;
  logic              vec_we;
  logic              vec_sel;
  logic [ADDR_W-1:0] vec_addr;
  logic [7:0]        vec_wdata;
  logic              exec_start;
  logic [3:0]        exec_op;
  logic [ADDR_W:0]   exec_len;
  logic              exec_done = 1'b0;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;

  cmd_sequencer #(
    .MAX_LEN(16)
`ifdef CMD_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_read   (in_read),
    .vec_we    (vec_we),
    .vec_sel   (vec_sel),
    .vec_addr  (vec_addr),
    .vec_wdata (vec_wdata),
    .exec_start(exec_start),
    .exec_op   (exec_op),
    .exec_len  (exec_len),
    .exec_done (exec_done),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  logic [7:0] byte_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, last_pop_cyc = 0, start_cyc = 0, done_cyc = 0, start_total = 0;
  int wr_cnt = 0, err_cnt = 0, err_multi = 0, start_multi = 0;
  logic err_prev = 1'b0, start_prev = 1'b0;
  logic [7:0] mem_a[16];
  logic [7:0] mem_b[16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: pop on a sampled in_read, then present the new head just after the edge.
  initial begin
    logic popped;
    forever begin
      @(posedge clk);
      popped = in_read;
      #1;
      if (popped && byte_q.size() > 0) void'(byte_q.pop_front());
      in_ready = (byte_q.size() != 0);
      in_data  = in_ready ? byte_q[0] : 8'h00;
    end
  end

  // Monitor on the falling edge: operand writes, error pulses and launches.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (in_read) last_pop_cyc = cyc;
      if (vec_we) begin
        wr_cnt++;
        if (vec_sel) mem_b[vec_addr] = vec_wdata;
        else         mem_a[vec_addr] = vec_wdata;
      end
      if (exec_start) begin
        start_cyc = cyc;
        start_total++;
        if (start_prev) start_multi++;
      end
      start_prev = exec_start;
      if (err) begin
        err_cnt++;
        if (err_prev) err_multi++;
      end
      err_prev = err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    wr_cnt  = 0;
    err_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
  endtask

  task automatic run_exec(input logic [3:0] op, input logic [4:0] len, input int dly);
    int n = 0;
    while (exec_start !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check_eq("start_seen", 64'(n < 300), 64'd1);
    check_eq("exec_op", 64'(exec_op), 64'(op));
    check_eq("exec_len", 64'(exec_len), 64'(len));
    check_eq("start_latency", 64'(start_cyc - last_pop_cyc), 64'd2);
    for (int i = 0; i < dly; i++) begin
      tick();
      check_eq("busy_wait", 64'(busy), 64'd1);
      check_eq("no_pop_wait", 64'(in_read), 64'd0);
      check_eq("op_held", 64'({exec_start, exec_op, exec_len}), 64'({1'b0, op, len}));
    end
    done_cyc  = cyc;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check_eq("busy_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int d1, s0, n;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("reset_outs", 64'({in_read, vec_we, vec_sel, vec_addr, vec_wdata, exec_start,
                                exec_op, exec_len, busy, err, err_code}), 64'd0);
    rst = 1'b0;
    tick();

    // Basic add, length 4.
    clear_sb();
    byte_q = {byte_q, 8'h01, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    run_exec(4'h1, 5'd4, 5);
    check_eq("add_wr_cnt", 64'(wr_cnt), 64'd8);
    check_eq("add_mem_a", 64'({mem_a[0], mem_a[1], mem_a[2], mem_a[3]}), 64'h10203040);
    check_eq("add_mem_b", 64'({mem_b[0], mem_b[1], mem_b[2], mem_b[3]}), 64'h01020304);
    check_eq("add_no_err", 64'(err_cnt), 64'd0);

    // Bad opcode then a length-1 sub.
    clear_sb();
    byte_q = {byte_q, 8'h17, 8'h02, 8'h01, 8'h05, 8'h03};
    run_exec(4'h2, 5'd1, 3);
    check_eq("badop_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("badop_code", 64'(err_code), 64'd1);
    check_eq("badop_wr_cnt", 64'(wr_cnt), 64'd2);
    check_eq("badop_data", 64'({mem_a[0], mem_b[0]}), 64'h0503);

    // Length 0 and length 17 both rejected; next byte is an opcode.
    clear_sb();
    byte_q = {byte_q, 8'h03, 8'h00, 8'h03, 8'h11, 8'h03, 8'h01, 8'h09, 8'h0A};
    run_exec(4'h3, 5'd1, 2);
    check_eq("len_err_cnt", 64'(err_cnt), 64'd2);
    check_eq("len_code", 64'(err_code), 64'd2);
    check_eq("len_wr_cnt", 64'(wr_cnt), 64'd2);
    check_eq("len_data", 64'({mem_a[0], mem_b[0]}), 64'h090A);

    // Backpressure: second packet waits in the FIFO during WAIT.
    clear_sb();
    byte_q = {byte_q, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                      8'h02, 8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
    run_exec(4'h1, 5'd2, 6);
    check_eq("bp_queued", 64'(byte_q.size()), 64'd6);
    d1 = done_cyc;
    run_exec(4'h2, 5'd2, 2);
    check_eq("bp_back_to_back", 64'(start_cyc - d1), 64'd8);
    check_eq("bp_wr_cnt", 64'(wr_cnt), 64'd8);
    check_eq("bp_data", 64'({mem_a[0], mem_a[1], mem_b[0], mem_b[1]}), 64'h55667788);
    s0 = start_total;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    repeat (3) tick();
    check_eq("idle_done_busy", 64'(busy), 64'd0);
    check_eq("idle_done_start", 64'(start_total - s0), 64'd0);

    // Reset after two of four A bytes.
    clear_sb();
    byte_q = {byte_q, 8'h04, 8'h04, 8'hC1, 8'hC2};
    n = 0;
    while (byte_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check_eq("mid_busy", 64'(busy), 64'd1);
    check_eq("mid_wr_cnt", 64'(wr_cnt), 64'd2);
    rst = 1'b1;
    tick();
    check_eq("midrst_outs", 64'({in_read, vec_we, vec_sel, vec_addr, vec_wdata, exec_start,
                                 exec_op, exec_len, busy, err, err_code}), 64'd0);
    rst = 1'b0;
    tick();
    byte_q = {byte_q, 8'h04, 8'h02, 8'hC1, 8'hC2, 8'hD1, 8'hD2};
    run_exec(4'h4, 5'd2, 1);
    check_eq("post_rst_wr_cnt", 64'(wr_cnt), 64'd6);
    check_eq("post_rst_data", 64'({mem_a[0], mem_a[1], mem_b[0], mem_b[1]}), 64'hC1C2D1D2);

    // Stalled packet: timeout when enabled, otherwise an indefinite wait.
    clear_sb();
    byte_q = {byte_q, 8'h01, 8'h03, 8'hAA};
`ifdef CMD_SEQ_TIMEOUT_EN
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq("tmo_window", 64'(n >= 50 && n <= 56), 64'd1);
    check_eq("tmo_code", 64'(err_code), 64'd3);
    check_eq("tmo_busy", 64'(busy), 64'd0);
    check_eq("tmo_wr_cnt", 64'(wr_cnt), 64'd1);
`else
    repeat (60) tick();
    check_eq("notmo_busy", 64'(busy), 64'd1);
    check_eq("notmo_err", 64'(err_cnt), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("notmo_rst_busy", 64'(busy), 64'd0);
`endif

    check_eq("err_one_cycle", 64'(err_multi), 64'd0);
    check_eq("start_one_cycle", 64'(start_multi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Sequences the UART input byte stream into accelerator commands.
- Pops bytes from the UART input block's FIFO through its read/ready/data handshake and parses packets. Each packet is an opcode byte, a length byte, then L bytes of vector A and L bytes of vector B.
- Writes operands into the vector operand RAM, launches the vector execution unit and waits for its completion.
- Sits between the UART input block and the vector datapath; it is the only master of both.

Parameters:
- MAX_LEN, 16, maximum vector length in elements (power of two, >=2).
- ADDR_W, $clog2(MAX_LEN), operand RAM address width.
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_ready  in  1  input FIFO non-empty; in_data valid while high.
- in_data  in  8  head byte of the input FIFO (first-word fall-through).
- in_read  out  1  pop strobe, one cycle per byte.
- vec_we  out  1  operand RAM write enable.
- vec_sel  out  1  operand bank select: 0 = A, 1 = B.
- vec_addr  out  ADDR_W  element index.
- vec_wdata  out  8  element data.
- exec_start  out  1  one-cycle launch pulse.
- exec_op  out  4  opcode, held stable from exec_start until exec_done.
- exec_len  out  ADDR_W+1  vector length, held like exec_op.
- exec_done  in  1  one-cycle completion pulse from the datapath.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle error pulse.
- err_code  out  2  cause of the error, held until the next err: 1 = bad opcode, 2 = bad length, 3 = timeout.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, on port rst, sampled on the clk rising edge.
- Reset values: all outputs 0; FSM goes to IDLE; internal counters 0.
- Reset mid-packet discards the partial packet. exec_op and exec_len clear.

Byte handshake:
- in_read is asserted only when in_ready=1 and the current state consumes a byte.
- The byte on in_data is captured in the same cycle in_read=1.
- Maximum rate is one byte per cycle; back-to-back pops are allowed while in_ready stays high.
- in_read is never asserted while in_ready=0.

FSM states:
- IDLE: on a byte, latch opcode = in_data[3:0]. Valid opcodes are 0x1 add, 0x2 sub, 0x3 mul, 0x4 dot.
  - in_data[7:4] != 0, or opcode not in the valid set: err pulse, err_code=1, stay in IDLE. The byte is consumed.
  - Otherwise go to LEN.
- LEN: on a byte, L = in_data.
  - L == 0 or L > MAX_LEN: err pulse, err_code=2, go to IDLE.
  - Otherwise idx=0, go to LOAD_A.
- LOAD_A: each consumed byte drives, in the same cycle (registered outputs valid the next cycle), vec_we=1, vec_sel=0, vec_addr=idx, vec_wdata=byte; then idx++.
  - The final element (idx == L-1) clears idx and moves to LOAD_B.
  - vec_we is asserted exactly once per consumed byte and never otherwise.
- LOAD_B: same as LOAD_A with vec_sel=1. The final element moves to START.
- START: exec_start=1 for exactly one cycle, exec_op and exec_len=L driven, then go to WAIT.
- WAIT: in_read is held 0, so bytes queue in the FIFO. On exec_done go to IDLE; a new packet may begin the next cycle.
- exec_done outside WAIT is ignored.

Latency: the last B byte popped leads to exec_start 2 cycles later (one cycle for the registered write, one in START).

Optional Feature:
- Macro: CMD_SEQ_TIMEOUT_EN.
- Defined: a counter runs in LEN, LOAD_A and LOAD_B. It resets on every consumed byte and on state entry.
  - On reaching TIMEOUT_CYCLES-1 without a byte: err pulse, err_code=3, go to IDLE, partial operands abandoned.
  - WAIT is not timed.
- Undefined: no counter exists; the FSM waits indefinitely and err_code 3 is never produced.

Decomposition:
- Shared package cmd_pkg:
  - opcode enum (OP_ADD=4'h1, OP_SUB=4'h2, OP_MUL=4'h3, OP_DOT=4'h4);
  - err_code enum (ERR_NONE, ERR_OP, ERR_LEN, ERR_TIMEOUT);
  - FSM state enum;
  - MAX_LEN default constant.
  - The datapath and TX formatter import the same package.
- Sub-module: none required. The timeout counter may be a small cmd_timeout instance, generated only under the macro.

Test Plan:
- Basic add: bytes 01,04,A0..A3=10,20,30,40, B0..B3=01,02,03,04 sent through the UART bench.
  - Expect 8 vec_we writes: A addresses 0-3 hold 10,20,30,40; B addresses 0-3 hold 01..04.
  - Then one exec_start with exec_op=1, exec_len=4.
  - busy stays high until exec_done is injected 5 cycles later.
- Bad opcode 0x17: err=1 for one cycle, err_code=1, no vec_we.
  - A following valid packet 02,01,05,03 is processed: exec_op=2, exec_len=1.
- Length errors:
  - packet 03,00: err_code=2;
  - packet 03,11 (17 > MAX_LEN): err_code=2.
  - In both cases the FSM returns to IDLE and the next byte is treated as an opcode.
- Backpressure: a second packet arrives while in WAIT.
  - Expect in_read=0 until exec_done, then the queued bytes pop back-to-back.
  - exec_done pulsed in IDLE is ignored.
- Reset in LOAD_A after 2 of 4 A bytes: all outputs 0 the next cycle.
  - A fresh packet 04,02,… completes normally with exec_len=2.
- Timeout (with CMD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50): stop after 01,03,AA.
  - 50 cycles later err=1, err_code=3, busy=0.
  - Without the macro, busy remains 1.
